// File: rtl/sqrt_rr_scheduler.sv
// Shares one psdsqrt datapath among NREQ requesters with round-robin grant.
// Latency: grant decided in cycle C, ack at C+1, done with result at C+3+SQRT_CYCLES.
// Backpressure: requests are levels held until ack; losers simply wait for a later IDLE.
module sqrt_rr_scheduler #(
    parameter int NBITSIN     = 16,
    parameter int NREQ        = 4,
    parameter int SQRT_CYCLES = 10,
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int RW = NBITSIN / 2,
    localparam int CW = (SQRT_CYCLES > 2) ? $clog2(SQRT_CYCLES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*NBITSIN-1:0]   xin_bus,
    output logic [NREQ-1:0]           ack,
    output logic [NREQ-1:0]           done,
    output logic [GW-1:0]             grant_id,
    output logic [RW-1:0]             result,
    output logic                      busy,
    output logic                      sq_start,
    output logic                      sq_stop,
    output logic [NBITSIN-1:0]        sq_xin,
    input  logic [RW-1:0]             sq_sqrt
);

    typedef enum logic [2:0] {IDLE, START, WAIT, STOP, CAPTURE} state_t;

    state_t               state, state_nxt;
    logic [GW-1:0]        ptr;
    logic [GW-1:0]        sel;
    logic                 found;
    logic [GW:0]          idx_w;
    logic [NBITSIN-1:0]   sel_x;
    logic [CW-1:0]        cnt;
    logic                 grant_now;

    function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First set request at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx_w = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, ptr} + (GW+1)'(k);
            if (idx_w >= (GW+1)'(NREQ))
                idx_w = idx_w - (GW+1)'(NREQ);
            if (!found && req[idx_w[GW-1:0]]) begin
                found = 1'b1;
                sel   = idx_w[GW-1:0];
            end
        end
    end

    always_comb begin
        sel_x = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel == GW'(k))
                sel_x = xin_bus[k*NBITSIN +: NBITSIN];
        end
    end

    assign grant_now = (state == IDLE) && found;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (cnt == CW'(SQRT_CYCLES - 2)) state_nxt = STOP;
            STOP:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decision so they line up with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            cnt      <= '0;
            ack      <= '0;
            done     <= '0;
            grant_id <= '0;
            result   <= '0;
            busy     <= 1'b0;
            sq_start <= 1'b0;
            sq_stop  <= 1'b0;
            sq_xin   <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            sq_start <= grant_now;
            ack      <= grant_now ? onehot(sel) : '0;
            sq_stop  <= (state == WAIT) && (state_nxt == STOP);
            done     <= (state == CAPTURE) ? onehot(grant_id) : '0;
            if (grant_now) begin
                sq_xin   <= sel_x;
                grant_id <= sel;
            end
            if (state == START)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + CW'(1);
            if (state == CAPTURE) begin
                result <= sq_sqrt;
                ptr    <= (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);
            end
        end
    end

endmodule

// File: doc/sqrt_rr_scheduler.md
Name: sqrt_rr_scheduler

Overview:
- Shares one sequential square-root datapath (psdsqrt, driven by start/stop pulses) among NREQ independent requesters.
- Uses round-robin arbitration and generates the start/stop sequence with a fixed cycle count.
- Captures the datapath result and returns it to the granted requester with a done pulse.
- Sits between the requester logic and a single psdsqrt instance; it replaces per-requester sequencing controllers.

Parameters:
- NBITSIN, 16: operand width; must be even. Result width is NBITSIN/2.
- NREQ, 4: number of requesters (2..8).
- SQRT_CYCLES, 10: clock cycles from the sq_start cycle to the sq_stop cycle. Must be ≥ the psdsqrt iteration count.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high reset; shared with psdsqrt.
- req  in  NREQ  level request, one bit per requester.
- xin_bus  in  NREQ*NBITSIN  operands; requester i occupies bits [i*NBITSIN +: NBITSIN].
- ack  out  NREQ  one-cycle pulse: operand of requester i accepted.
- done  out  NREQ  one-cycle pulse: result for requester i valid on result.
- grant_id  out  $clog2(NREQ) (min 1)  index of the requester currently or last served.
- result  out  NBITSIN/2  last captured square root; held until the next capture.
- busy  out  1  high whenever state != IDLE.
- sq_start  out  1  to psdsqrt start.
- sq_stop  out  1  to psdsqrt stop.
- sq_xin  out  NBITSIN  to psdsqrt xin; registered.
- sq_sqrt  in  NBITSIN/2  from psdsqrt sqrt.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ack, done, sq_start, sq_stop, busy = 0.
  - sq_xin=0, result=0, grant_id=0.
  - RR pointer=0; cycle counter=0.
- All outputs are registered; no combinational path from req to any output.
- FSM states: IDLE, START, WAIT, STOP, CAPTURE.
- IDLE, when any req bit is high in cycle C:
  - Select the first set bit searching from pointer p upward, wrapping modulo NREQ.
  - Latch its operand into sq_xin and its index into grant_id.
  - Go to START.
- IDLE with no req set: remain in IDLE.
- START (cycle C+1):
  - sq_start=1 and ack[grant_id]=1, both for exactly this cycle.
  - Clear the counter; go to WAIT.
- WAIT: increment the counter each cycle; go to STOP when counter == SQRT_CYCLES-2.
- STOP (cycle C+1+SQRT_CYCLES): sq_stop=1 for one cycle; go to CAPTURE.
- CAPTURE (cycle C+2+SQRT_CYCLES):
  - Sample sq_sqrt into result.
  - done[grant_id]=1 in the next cycle (C+3+SQRT_CYCLES), with result already valid.
  - p ← (grant_id+1) mod NREQ; go to IDLE.
- Earliest next grant decision is in cycle C+3+SQRT_CYCLES, which gives a throughput of one sqrt per SQRT_CYCLES+3 cycles.
- Requester contract:
  - Hold req high and xin stable until ack is seen.
  - Drop req in the cycle after ack.
  - req still high when the FSM next reaches IDLE counts as a new request.
- A req rising while busy is queued implicitly; it is evaluated at the next IDLE by the RR order.
- A req dropped before its ack is never served; no error is flagged.
- Simultaneous requests: only one grant per IDLE visit. No requester waits more than NREQ-1 services.
- sq_xin is stable from START through CAPTURE. sq_start and sq_stop are never high in the same cycle.
- Reset mid-operation:
  - Any partial operation is abandoned; no done is issued.
  - psdsqrt is reset by the same signal; pointer returns to 0.
- sq_sqrt is not truncated or extended; it is passed unchanged into result.

Test Plan:
- Single request (NBITSIN=16, NREQ=4, SQRT_CYCLES=10): req[0] with x=100 sampled in cycle C → ack[0] and sq_start at C+1, sq_stop at C+11, done[0] at C+13, result=10, grant_id=0, busy low at C+13.
- Simultaneous requests: req[3:0]=1111 with x0=100, x1=12, x2=13, x3=1057 → done order 0,1,2,3 with results 10,3,3,32; successive sq_start pulses spaced exactly 13 cycles.
- Fairness: req[0] held high continuously, req[2] raised once while serving 0 → order 0,2,0,…; req[2] served within one service slot.
- Boundary operands: x=0 → 0; x=1 → 1; x=65535 → 255; x=4300 → 65; result holds its value between done pulses.
- Reset during WAIT: reset asserted mid-computation of x=4300 → all outputs 0 immediately with no done; after release, a request on req[1] is granted first-found from pointer 0 and completes correctly (x=144 → 12).
- Protocol checks on every test: exactly one ack and one done per served request; sq_start/sq_stop never overlap; sq_xin unchanged from START to CAPTURE.
